fec_cc_encoder: RTL and testbench

FEC_CC_ENCODER -- requirements
Module: fec_cc_encoder

---
 rtl/wimax_pkg.sv | 28 ++
 rtl/fec_cc_encoder_if.sv | 15 +
 rtl/fec_pingpong_buf.sv | 98 +++++++++
 rtl/fec_cc_encoder.sv | 151 +++++++++++++++
 tb/tb_fec_cc_encoder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wimax_pkg.sv
// Shared definitions for the WiMAX OFDM FEC chain.
// Holds the default block size and convolutional generators, the ping-pong
// bank state and read FSM enums, and the generator tap helper.
package wimax_pkg;

  localparam int         WIMAX_BLOCK_BITS = 96;
  localparam logic [6:0] WIMAX_G1         = 7'o171;  // X output
  localparam logic [6:0] WIMAX_G2         = 7'o133;  // Y output

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_PRELOAD = 2'd1,
    RD_ENCODE  = 2'd2
  } rd_state_e;

  // win[6] = current input bit, win[0] = input delayed by 6.
  function automatic logic cc_tap(input logic [6:0] gen, input logic [6:0] win);
    return ^(gen & win);
  endfunction

endpackage

// File: rtl/fec_cc_encoder_if.sv
// Serial one-bit stream bundle used between FEC stages.
//   data  : payload bit
//   valid : source has a bit on data
//   ready : sink can take a bit
// Handshake: a bit transfers on a rising clock edge where valid && ready are
// both high. Once valid is raised the source keeps data and valid steady
// until that transfer; ready may change freely and does not depend on valid.
interface fec_cc_encoder_if;
  logic data;
  logic valid;
  logic ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fec_pingpong_buf.sv
// Two-bank ping-pong store for randomized bits awaiting encoding.
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   wr (slave)          : serial input stream; wr.ready is a flop
//   rd_start            : oldest bank (after any rd_done this cycle) -> READING
//   rd_done             : reading bank -> EMPTY, read pointer moves on
//   rd_addr / rd_bit    : combinational random read of the reading bank
//   rd_tail             : last six bits of the reading bank, [5] = last bit
//   oldest_full         : bank at the read pointer is FULL
//   other_full          : the bank behind the read pointer is FULL
module fec_pingpong_buf
  import wimax_pkg::*;
#(
  parameter int BLOCK_BITS = WIMAX_BLOCK_BITS,
  localparam int CW = $clog2(BLOCK_BITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  fec_cc_encoder_if.slave       wr,
  input  logic                  rd_start,
  input  logic                  rd_done,
  input  logic [CW-1:0]         rd_addr,
  output logic                  rd_bit,
  output logic [5:0]            rd_tail,
  output logic                  oldest_full,
  output logic                  other_full
);

  logic [BLOCK_BITS-1:0] mem_q [2];
  logic [BLOCK_BITS-1:0] mem_d [2];
  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  accept;

  assign wr.ready    = ready_q;
  assign accept      = wr.valid && ready_q;
  assign rd_bit      = mem_q[rd_bank_q][rd_addr];
  assign rd_tail     = mem_q[rd_bank_q][BLOCK_BITS-1 -: 6];
  assign oldest_full = (bank_q[rd_bank_q] == BANK_FULL);
  assign other_full  = (bank_q[!rd_bank_q] == BANK_FULL);

  always_comb begin
    mem_d     = mem_q;
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;

    // Release first so a start in the same cycle claims the next bank.
    if (rd_done) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = !rd_bank_q;
    end
    if (rd_start) begin
      bank_d[rd_bank_d] = BANK_READING;
    end

    // The write bank is never the reading bank while ready is high.
    if (accept) begin
      mem_d[wr_bank_q][wr_cnt_q] = wr.data;
      if (wr_cnt_q == CW'(BLOCK_BITS - 1)) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d          = wr_cnt_q + CW'(1);
      end
    end

    ready_d = (bank_d[wr_bank_d] == BANK_EMPTY) || (bank_d[wr_bank_d] == BANK_FILLING);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i]  <= '0;
        bank_q[i] <= BANK_EMPTY;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: rtl/fec_cc_encoder.sv
// Rate-1/2, K=7 tail-biting convolutional encoder (802.16 OFDM FEC).
// Input bits are collected per block in a ping-pong buffer; each full block
// is encoded as X0,Y0,X1,Y1,... with the encoder state preloaded from the
// block's last six bits so the trellis starts and ends in the same state.
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   data_in/valid_in      : serial input bit, transfers when ready_out is high
//   ready_out             : registered, high while the write bank has room
//   data_out/valid_out    : registered serial encoded bit
//   ready_in              : downstream accepts data_out
//   dbg_rd_state          : read FSM state
module fec_cc_encoder
  import wimax_pkg::*;
#(
  parameter int         BLOCK_BITS = WIMAX_BLOCK_BITS,
  parameter logic [6:0] G1         = WIMAX_G1,
  parameter logic [6:0] G2         = WIMAX_G2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      data_in,
  input  logic      valid_in,
  output logic      ready_out,
  output logic      data_out,
  output logic      valid_out,
  input  logic      ready_in,
  output rd_state_e dbg_rd_state
);

  localparam int            CW       = $clog2(BLOCK_BITS);
  localparam int            OW       = $clog2(2 * BLOCK_BITS);
  localparam logic [OW-1:0] LAST_IDX = OW'(2 * BLOCK_BITS - 1);

  fec_cc_encoder_if wr_if ();
  assign wr_if.data  = data_in;
  assign wr_if.valid = valid_in;
  assign ready_out   = wr_if.ready;

  rd_state_e     st_q, st_d;
  logic [5:0]    enc_q, enc_d;      // [5] = delay 1 ... [0] = delay 6
  logic [OW-1:0] idx_q, idx_d;      // output bit index presented / next
  logic          cur_q, cur_d;      // input bit k being encoded
  logic          dout_q, dout_d;
  logic          vout_q, vout_d;

  logic          rd_start, rd_done, rd_bit, oldest_full, other_full;
  logic [5:0]    rd_tail;
  logic [CW-1:0] rd_addr;
  logic [OW-1:0] load_idx;
  logic          load;
  logic [6:0]    window;

  fec_pingpong_buf #(.BLOCK_BITS(BLOCK_BITS)) u_buf (
    .clock       (clock),
    .reset       (reset),
    .wr          (wr_if),
    .rd_start    (rd_start),
    .rd_done     (rd_done),
    .rd_addr     (rd_addr),
    .rd_bit      (rd_bit),
    .rd_tail     (rd_tail),
    .oldest_full (oldest_full),
    .other_full  (other_full)
  );

  assign data_out     = dout_q;
  assign valid_out    = vout_q;
  assign dbg_rd_state = st_q;

  always_comb begin
    st_d     = st_q;
    enc_d    = enc_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    dout_d   = dout_q;
    vout_d   = vout_q;
    rd_start = 1'b0;
    rd_done  = 1'b0;
    load     = 1'b0;
    window   = '0;

    // The bit to load next is the one after the presented bit, or the
    // first bit when nothing is presented yet.
    load_idx = vout_q ? (idx_q + OW'(1)) : idx_q;
    rd_addr  = CW'(load_idx >> 1);

    case (st_q)
      RD_IDLE: begin
        if (oldest_full) begin
          rd_start = 1'b1;
          st_d     = RD_PRELOAD;
        end
      end
      RD_PRELOAD: begin
        enc_d  = rd_tail;
        idx_d  = '0;
        vout_d = 1'b0;
        st_d   = RD_ENCODE;
      end
      RD_ENCODE: begin
        if (!vout_q) begin
          load = 1'b1;
        end else if (ready_in) begin
          // Bit k enters the shift register only once Yk has been taken.
          if (idx_q[0]) enc_d = {cur_q, enc_q[5:1]};
          if (idx_q == LAST_IDX) begin
            vout_d  = 1'b0;
            idx_d   = '0;
            rd_done = 1'b1;
            if (other_full) begin
              rd_start = 1'b1;
              st_d     = RD_PRELOAD;
            end else begin
              st_d = RD_IDLE;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: st_d = RD_IDLE;
    endcase

    if (load) begin
      idx_d  = load_idx;
      vout_d = 1'b1;
      window = {rd_bit, enc_d};
      dout_d = load_idx[0] ? cc_tap(G2, window) : cc_tap(G1, window);
      if (!load_idx[0]) cur_d = rd_bit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= RD_IDLE;
      enc_q  <= '0;
      idx_q  <= '0;
      cur_q  <= 1'b0;
      dout_q <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      enc_q  <= enc_d;
      idx_q  <= idx_d;
      cur_q  <= cur_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
    end
  end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Bench for fec_cc_encoder: directed blocks, back-pressure, random traffic
// and mid-block reset, checked against a circular-convolution model.
module tb_fec_cc_encoder;
  import wimax_pkg::*;

  localparam int BB = 96;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  fec_cc_encoder_if in_if ();
  fec_cc_encoder_if out_if ();
  rd_state_e dbg_state;

  fec_cc_encoder #(.BLOCK_BITS(BB), .G1(7'o171), .G2(7'o133)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (in_if.data),
    .valid_in     (in_if.valid),
    .ready_out    (in_if.ready),
    .data_out     (out_if.data),
    .valid_out    (out_if.valid),
    .ready_in     (out_if.ready),
    .dbg_rd_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int total = 0;
  int bad = 0;
  logic [6:0] g1 = 7'o171;
  logic [6:0] g2 = 7'o133;

  int  acc_cnt = 0;
  int  last_acc_cyc = 0;
  int  rise_cyc = -1;
  int  run_len = 0;
  int  last_run = 0;
  bit  give_up = 0;
  bit  rand_ready = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: Xk/Yk are generator-weighted parities over input bits
  // k, k-1, ..., k-6 taken circularly around the block.
  function automatic void push_expected(input logic [BB-1:0] blk);
    for (int k = 0; k < BB; k++) begin
      int x = 0;
      int y = 0;
      for (int j = 0; j < 7; j++) begin
        int src = (k - j + BB) % BB;
        if (g1[6-j] && blk[src]) x ^= 1;
        if (g2[6-j] && blk[src]) y ^= 1;
      end
      exp_q.push_back(x[0]);
      exp_q.push_back(y[0]);
    end
  endfunction

  function automatic int ones_in(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < got_q.size(); i++) n += int'(got_q[i]);
    return n;
  endfunction

  // ---------------- monitor ----------------
  logic prev_stall = 1'b0;
  logic prev_d = 1'b0;
  logic prev_v = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_v     = 1'b0;
      run_len    = 0;
    end else begin
      if (prev_stall) begin
        check_bit("stall_valid", out_if.valid, 1'b1);
        check_bit("stall_data", out_if.data, prev_d);
      end
      if (out_if.valid && !prev_v) rise_cyc = cyc;
      if (out_if.valid) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (out_if.valid && out_if.ready) begin
        got_q.push_back(out_if.data);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got bit=%0b want no output (cycle %0d)", out_if.data, cyc);
        end else begin
          check_bit("data_out", out_if.data, exp_q.pop_front());
        end
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_d     = out_if.data;
      prev_v     = out_if.valid;
    end
  end

  always @(posedge clock) begin
    if (rand_ready) begin
      #1;
      out_if.ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  task automatic send_bit(input logic b, input int max_gap);
    int guard = 0;
    if (give_up) return;
    if (max_gap > 0) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clock);
        #1;
      end
    end
    in_if.data  = b;
    in_if.valid = 1'b1;
    do begin
      @(negedge clock);
      guard++;
    end while (!in_if.ready && guard < 3000);
    if (!in_if.ready) begin
      total++;
      bad++;
      give_up = 1;
      $display("FAIL ready_timeout: ready_out got=0 want=1 after %0d cycles", guard);
    end else begin
      acc_cnt++;
      last_acc_cyc = cyc + 1;
    end
    @(posedge clock);
    #1;
    in_if.valid = 1'b0;
    in_if.data  = 1'b0;
  endtask

  task automatic send_block(input logic [BB-1:0] blk, input int max_gap);
    push_expected(blk);
    for (int i = 0; i < BB; i++) send_bit(blk[i], max_gap);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_if.valid) && guard < 8000) begin
      @(negedge clock);
      guard++;
    end
    check_int("drain_left", exp_q.size(), 0);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BB-1:0] rand_block();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [BB-1:0] blk;
    logic [BB-1:0] b1, b2, b3;
    logic [13:0]   pat14;
    logic [11:0]   pat12;
    int            base;
    int            stale;

    in_if.valid  = 1'b0;
    in_if.data   = 1'b0;
    out_if.ready = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check_bit("rst_ready_out", in_if.ready, 1'b0);
    check_bit("rst_valid_out", out_if.valid, 1'b0);
    check_bit("rst_data_out", out_if.data, 1'b0);
    check_int("rst_fsm", int'(dbg_state), int'(RD_IDLE));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_bit("ready_first_edge", in_if.ready, 1'b1);

    // all-zero block
    out_if.ready = 1'b1;
    blk = '0;
    got_q.delete();
    send_block(blk, 0);
    drain();
    check_int("zero_latency", rise_cyc - last_acc_cyc, 3);
    check_int("zero_count", got_q.size(), 2 * BB);
    check_int("zero_ones", ones_in(0, 2 * BB - 1), 0);
    check_int("zero_run", last_run, 2 * BB);

    // impulse at bit 0
    blk = '0;
    blk[0] = 1'b1;
    pat14 = 14'b11101111000111;
    got_q.delete();
    send_block(blk, 0);
    drain();
    check_int("imp0_count", got_q.size(), 2 * BB);
    for (int i = 0; i < 14; i++) check_bit("imp0_head", got_q[i], pat14[13-i]);
    check_int("imp0_tail_ones", ones_in(14, 2 * BB - 1), 0);

    // impulse at last bit: wraps into both ends of the output
    blk = '0;
    blk[BB-1] = 1'b1;
    pat12 = 12'b101111000111;
    got_q.delete();
    send_block(blk, 0);
    drain();
    check_int("imp95_count", got_q.size(), 2 * BB);
    for (int i = 0; i < 12; i++) check_bit("imp95_head", got_q[i], pat12[11-i]);
    check_int("imp95_mid_ones", ones_in(12, 2 * BB - 3), 0);
    check_bit("imp95_last_x", got_q[2*BB-2], 1'b1);
    check_bit("imp95_last_y", got_q[2*BB-1], 1'b1);

    // three blocks against a blocked output
    out_if.ready = 1'b0;
    got_q.delete();
    b1 = rand_block();
    b2 = rand_block();
    b3 = rand_block();
    base = acc_cnt;
    send_block(b1, 0);
    send_block(b2, 0);
    repeat (10) @(negedge clock);
    check_bit("full_ready_low", in_if.ready, 1'b0);
    @(posedge clock);
    #1;
    fork
      send_block(b3, 0);
      begin
        repeat (40) @(negedge clock);
        check_int("full_accepted", acc_cnt - base, 2 * BB);
        check_bit("full_ready_still_low", in_if.ready, 1'b0);
        @(posedge clock);
        #1;
        out_if.ready = 1'b1;
      end
    join
    drain();
    check_int("b2b_count", got_q.size(), 6 * BB);

    // random traffic on both sides
    got_q.delete();
    rand_ready = 1;
    for (int n = 0; n < 20; n++) send_block(rand_block(), 3);
    rand_ready = 0;
    @(posedge clock);
    #2;
    out_if.ready = 1'b1;
    drain();
    check_int("rand_count", got_q.size(), 20 * 2 * BB);

    // reset in the middle of the second block
    send_block(rand_block(), 0);
    push_expected(rand_block());
    for (int i = 0; i <= 50; i++) send_bit($urandom_range(0, 1) != 0, 0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_bit("mid_rst_valid", out_if.valid, 1'b0);
    check_bit("mid_rst_data", out_if.data, 1'b0);
    check_bit("mid_rst_ready", in_if.ready, 1'b0);
    repeat (3) @(negedge clock);
    check_int("mid_rst_fsm", int'(dbg_state), int'(RD_IDLE));
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_bit("mid_rst_ready_up", in_if.ready, 1'b1);
    stale = 0;
    repeat (20) begin
      @(negedge clock);
      if (out_if.valid) stale++;
    end
    check_int("no_stale_out", stale, 0);
    @(posedge clock);
    #1;
    got_q.delete();
    send_block(rand_block(), 1);
    drain();
    check_int("post_rst_count", got_q.size(), 2 * BB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
